hash_result_serializer: RTL and testbench

Consumer-side counterpart of the hash engine. It accepts one wide hash-result beat, `HASH_ISSUE_WIDTH` positions per beat, from the hash engine output (the post-PE scheduler stage). It emits one record per position whose row is valid, in ascending position order, over a narrow per-position valid/ready interface that feeds the downstream match-selection logic. Delimiters are carried so that exactly one emitted record per delimited beat is marked `output_delim`.

---
 rtl/hash_result_serializer.sv | 209 ++++++++++++++++++++
 tb/tb_hash_result_serializer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hash_result_serializer.sv
// hash_result_serializer: breaks one wide hash-result beat into per-position
// records in ascending position order. A beat with no valid rows but with a
// delimiter becomes a single marker record, so every delimited beat produces
// exactly one record flagged output_delim.

`ifndef HASH_ISSUE_WIDTH
`define HASH_ISSUE_WIDTH 4
`endif
`ifndef ROW_SIZE
`define ROW_SIZE 2
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef META_MATCH_LEN_WIDTH
`define META_MATCH_LEN_WIDTH 4
`endif

module hash_result_serializer #(
  parameter int ISSUE_WIDTH = `HASH_ISSUE_WIDTH,
  parameter int ROW_SIZE    = `ROW_SIZE,
  parameter int ADDR_WIDTH  = `ADDR_WIDTH,
  parameter int MLEN_W      = `META_MATCH_LEN_WIDTH
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  // wide input beat
  input  logic                                    input_valid,
  output logic                                    input_ready,
  input  logic [ADDR_WIDTH-1:0]                   input_head_addr,
  input  logic [ISSUE_WIDTH-1:0]                  input_row_valid,
  input  logic [ISSUE_WIDTH*ROW_SIZE-1:0]         input_history_valid_vec,
  input  logic [ISSUE_WIDTH*ROW_SIZE*ADDR_WIDTH-1:0] input_history_addr_vec,
  input  logic [ISSUE_WIDTH*ROW_SIZE*MLEN_W-1:0]  input_meta_match_len_vec,
  input  logic [ISSUE_WIDTH*ROW_SIZE-1:0]         input_meta_match_can_ext_vec,
  input  logic [ISSUE_WIDTH*8-1:0]                input_data,
  input  logic                                    input_delim,
  // narrow per-position output
  output logic                                    output_valid,
  input  logic                                    output_ready,
  output logic [ADDR_WIDTH-1:0]                   output_addr,
  output logic                                    output_row_valid,
  output logic [ROW_SIZE-1:0]                     output_history_valid_vec,
  output logic [ROW_SIZE*ADDR_WIDTH-1:0]          output_history_addr_vec,
  output logic [ROW_SIZE*MLEN_W-1:0]              output_meta_match_len_vec,
  output logic [ROW_SIZE-1:0]                     output_meta_match_can_ext_vec,
  output logic [7:0]                              output_literal,
  output logic                                    output_last,
  output logic                                    output_delim
);

  localparam int IDX_W = (ISSUE_WIDTH > 1) ? $clog2(ISSUE_WIDTH) : 1;
  localparam int HA_W  = ROW_SIZE * ADDR_WIDTH;
  localparam int ML_W  = ROW_SIZE * MLEN_W;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  // FSM and bookkeeping
  state_t                   r_state;
  state_t                   w_state_next;
  logic [ISSUE_WIDTH-1:0]   r_pend_mask;
  logic [ISSUE_WIDTH-1:0]   w_pend_mask_next;
  logic                     r_marker;
  logic                     w_marker_next;

  // captured beat
  logic [ADDR_WIDTH-1:0]                     r_head_addr;
  logic [ISSUE_WIDTH*ROW_SIZE-1:0]           r_hist_valid;
  logic [ISSUE_WIDTH*ROW_SIZE*ADDR_WIDTH-1:0] r_hist_addr;
  logic [ISSUE_WIDTH*ROW_SIZE*MLEN_W-1:0]    r_mlen;
  logic [ISSUE_WIDTH*ROW_SIZE-1:0]           r_can_ext;
  logic [ISSUE_WIDTH*8-1:0]                  r_data;
  logic                                      r_delim;

  // per-position views of the captured beat
  logic [ROW_SIZE-1:0] w_pos_hv  [ISSUE_WIDTH];
  logic [HA_W-1:0]     w_pos_ha  [ISSUE_WIDTH];
  logic [ML_W-1:0]     w_pos_ml  [ISSUE_WIDTH];
  logic [ROW_SIZE-1:0] w_pos_ce  [ISSUE_WIDTH];
  logic [7:0]          w_pos_lit [ISSUE_WIDTH];

  logic [IDX_W-1:0]       w_idx;
  logic                   w_any_pend;
  logic                   w_onehot;
  logic                   w_last;
  logic                   w_out_valid;
  logic                   w_out_fire;
  logic                   w_in_ready;
  logic                   w_in_fire;
  logic [ISSUE_WIDTH-1:0] w_mask_minus1;

  genvar gi;
  generate
    for (gi = 0; gi < ISSUE_WIDTH; gi++) begin : g_pos
      assign w_pos_hv[gi]  = r_hist_valid[gi*ROW_SIZE +: ROW_SIZE];
      assign w_pos_ha[gi]  = r_hist_addr[gi*HA_W +: HA_W];
      assign w_pos_ml[gi]  = r_mlen[gi*ML_W +: ML_W];
      assign w_pos_ce[gi]  = r_can_ext[gi*ROW_SIZE +: ROW_SIZE];
      assign w_pos_lit[gi] = r_data[gi*8 +: 8];
    end
  endgenerate

  // lowest pending position wins (scan from the top so the lowest overwrites)
  always_comb begin
    w_idx = '0;
    for (int i = ISSUE_WIDTH - 1; i >= 0; i--) begin
      if (r_pend_mask[i]) begin
        w_idx = IDX_W'(i);
      end
    end
  end

  assign w_any_pend    = |r_pend_mask;
  assign w_mask_minus1 = r_pend_mask - {{(ISSUE_WIDTH-1){1'b0}}, 1'b1};
  assign w_onehot      = w_any_pend && ((r_pend_mask & w_mask_minus1) == '0);
  assign w_last        = w_onehot || r_marker;
  assign w_out_valid   = (r_state == ST_EMIT);
  assign w_out_fire    = w_out_valid && output_ready;

  // ready while idle, or when the last record of the beat leaves this cycle
  assign w_in_ready = rst_n && ((r_state == ST_IDLE) || (w_out_fire && w_last));
  assign w_in_fire  = input_valid && w_in_ready;
  assign input_ready = w_in_ready;

  // output record: sliced from the captured beat at the current index
  always_comb begin
    output_valid                  = w_out_valid;
    output_row_valid              = 1'b0;
    output_addr                   = r_head_addr + ADDR_WIDTH'(w_idx);
    output_history_valid_vec      = '0;
    output_history_addr_vec       = '0;
    output_meta_match_len_vec     = '0;
    output_meta_match_can_ext_vec = '0;
    output_literal                = '0;
    output_last                   = w_last;
    output_delim                  = w_last && r_delim;
    if (r_marker) begin
      // marker carries only the delimiter, pointing at the beat's last address
      output_addr = r_head_addr + ADDR_WIDTH'(ISSUE_WIDTH - 1);
    end else begin
      output_row_valid              = w_any_pend;
      output_history_valid_vec      = w_pos_hv[w_idx];
      output_history_addr_vec       = w_pos_ha[w_idx];
      output_meta_match_len_vec     = w_pos_ml[w_idx];
      output_meta_match_can_ext_vec = w_pos_ce[w_idx];
      output_literal                = w_pos_lit[w_idx];
    end
  end

  // next state: retire the presented record, then a capture overrides
  always_comb begin
    w_state_next     = r_state;
    w_pend_mask_next = r_pend_mask;
    w_marker_next    = r_marker;
    if (w_out_fire) begin
      if (r_marker) begin
        w_marker_next = 1'b0;
      end else begin
        w_pend_mask_next[w_idx] = 1'b0;
      end
      if (w_last) begin
        w_state_next = ST_IDLE;
      end
    end
    if (w_in_fire) begin
      w_pend_mask_next = input_row_valid;
      w_marker_next    = (input_row_valid == '0) && input_delim;
      w_state_next     = ((input_row_valid != '0) || input_delim) ? ST_EMIT : ST_IDLE;
    end
  end

  // state and bookkeeping registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_pend_mask <= '0;
      r_marker    <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_pend_mask <= w_pend_mask_next;
      r_marker    <= w_marker_next;
    end
  end

  // beat payload is loaded on every accepted beat and held until the next one
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_head_addr  <= '0;
      r_hist_valid <= '0;
      r_hist_addr  <= '0;
      r_mlen       <= '0;
      r_can_ext    <= '0;
      r_data       <= '0;
      r_delim      <= 1'b0;
    end else if (w_in_fire) begin
      r_head_addr  <= input_head_addr;
      r_hist_valid <= input_history_valid_vec;
      r_hist_addr  <= input_history_addr_vec;
      r_mlen       <= input_meta_match_len_vec;
      r_can_ext    <= input_meta_match_can_ext_vec;
      r_data       <= input_data;
      r_delim      <= input_delim;
    end
  end

endmodule

// File: tb/tb_hash_result_serializer.sv
// Directed bench for hash_result_serializer with hand-computed expectations.
module tb_hash_result_serializer;

  localparam int IW = 4;
  localparam int RS = 2;
  localparam int AW = 16;
  localparam int MW = 4;

  logic              clk;
  logic              rst_n;
  logic              input_valid;
  logic              input_ready;
  logic [AW-1:0]     input_head_addr;
  logic [IW-1:0]     input_row_valid;
  logic [IW*RS-1:0]  input_history_valid_vec;
  logic [IW*RS*AW-1:0] input_history_addr_vec;
  logic [IW*RS*MW-1:0] input_meta_match_len_vec;
  logic [IW*RS-1:0]  input_meta_match_can_ext_vec;
  logic [IW*8-1:0]   input_data;
  logic              input_delim;
  logic              output_valid;
  logic              output_ready;
  logic [AW-1:0]     output_addr;
  logic              output_row_valid;
  logic [RS-1:0]     output_history_valid_vec;
  logic [RS*AW-1:0]  output_history_addr_vec;
  logic [RS*MW-1:0]  output_meta_match_len_vec;
  logic [RS-1:0]     output_meta_match_can_ext_vec;
  logic [7:0]        output_literal;
  logic              output_last;
  logic              output_delim;

  hash_result_serializer #(
    .ISSUE_WIDTH(IW), .ROW_SIZE(RS), .ADDR_WIDTH(AW), .MLEN_W(MW)
  ) dut (
    .clk                           (clk),
    .rst_n                         (rst_n),
    .input_valid                   (input_valid),
    .input_ready                   (input_ready),
    .input_head_addr               (input_head_addr),
    .input_row_valid               (input_row_valid),
    .input_history_valid_vec       (input_history_valid_vec),
    .input_history_addr_vec        (input_history_addr_vec),
    .input_meta_match_len_vec      (input_meta_match_len_vec),
    .input_meta_match_can_ext_vec  (input_meta_match_can_ext_vec),
    .input_data                    (input_data),
    .input_delim                   (input_delim),
    .output_valid                  (output_valid),
    .output_ready                  (output_ready),
    .output_addr                   (output_addr),
    .output_row_valid              (output_row_valid),
    .output_history_valid_vec      (output_history_valid_vec),
    .output_history_addr_vec       (output_history_addr_vec),
    .output_meta_match_len_vec     (output_meta_match_len_vec),
    .output_meta_match_can_ext_vec (output_meta_match_can_ext_vec),
    .output_literal                (output_literal),
    .output_last                   (output_last),
    .output_delim                  (output_delim)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // hand-decoded per-position slices of the fixed payload driven below
  logic [1:0]  exp_hv  [4] = '{2'b01, 2'b11, 2'b01, 2'b10};
  logic [31:0] exp_ha  [4] = '{32'h1001_1000, 32'h2001_2000, 32'h3001_3000, 32'h4001_4000};
  logic [7:0]  exp_ml  [4] = '{8'h21, 8'h43, 8'h65, 8'h87};
  logic [1:0]  exp_ce  [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
  logic [7:0]  exp_lit [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_beat(input logic [15:0] head, input logic [3:0] rv, input logic dl);
    input_valid     = 1'b1;
    input_head_addr = head;
    input_row_valid = rv;
    input_delim     = dl;
  endtask

  task automatic check_rec(input string tag, input int pos, input logic [15:0] addr,
                           input logic last, input logic dl);
    check({tag, " valid"},   output_valid, 1'b1);
    check({tag, " rowv"},    output_row_valid, 1'b1);
    check({tag, " addr"},    output_addr, addr);
    check({tag, " hv"},      output_history_valid_vec, exp_hv[pos]);
    check({tag, " ha"},      output_history_addr_vec, exp_ha[pos]);
    check({tag, " ml"},      output_meta_match_len_vec, exp_ml[pos]);
    check({tag, " ce"},      output_meta_match_can_ext_vec, exp_ce[pos]);
    check({tag, " lit"},     output_literal, exp_lit[pos]);
    check({tag, " last"},    output_last, last);
    check({tag, " delim"},   output_delim, dl);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       bp_ready [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    int         bp_pos   [6] = '{0, 1, 1, 1, 2, 3};
    logic [15:0] wrap_a  [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};

    rst_n        = 1'b0;
    input_valid  = 1'b0;
    output_ready = 1'b1;
    input_head_addr = '0;
    input_row_valid = '0;
    input_delim     = 1'b0;
    input_history_valid_vec      = 8'b10_01_11_01;
    input_history_addr_vec       = 128'h4001_4000_3001_3000_2001_2000_1001_1000;
    input_meta_match_len_vec     = 32'h8765_4321;
    input_meta_match_can_ext_vec = 8'b00_11_10_01;
    input_data                   = 32'hDD_CC_BB_AA;

    // reset state
    @(negedge clk);
    next_cycle();
    #1;
    check("rst in_ready", input_ready, 1'b0);
    check("rst out_valid", output_valid, 1'b0);
    check("rst addr", output_addr, 16'h0000);
    check("rst hv", output_history_valid_vec, 2'b00);
    check("rst last", output_last, 1'b0);
    rst_n = 1'b1;
    #1;
    check("rel in_ready", input_ready, 1'b1);

    // full beat, ready held high
    drive_beat(16'h0100, 4'b1111, 1'b0);
    #1;
    check("full accept", input_ready, 1'b1);
    next_cycle();
    input_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check_rec($sformatf("full%0d", k), k, 16'h0100 + 16'(k), k == 3, 1'b0);
      check($sformatf("full%0d in_ready", k), input_ready, k == 3);
      $display("full beat record %0d addr=%h", k, output_addr);
      next_cycle();
    end
    #1;
    check("full done", output_valid, 1'b0);

    // sparse delimited beat
    drive_beat(16'h0300, 4'b1010, 1'b1);
    next_cycle();
    input_valid = 1'b0;
    #1;
    check_rec("sparse1", 1, 16'h0301, 1'b0, 1'b0);
    next_cycle();
    #1;
    check_rec("sparse3", 3, 16'h0303, 1'b1, 1'b1);
    next_cycle();
    #1;
    check("sparse done", output_valid, 1'b0);
    $display("sparse beat done");

    // empty non-delimited beat
    drive_beat(16'h0400, 4'b0000, 1'b0);
    #1;
    check("empty accept", input_ready, 1'b1);
    next_cycle();
    input_valid = 1'b0;
    #1;
    check("empty no out", output_valid, 1'b0);
    check("empty ready", input_ready, 1'b1);

    // delim-only marker beat
    drive_beat(16'h0200, 4'b0000, 1'b1);
    next_cycle();
    input_valid = 1'b0;
    #1;
    check("mark valid", output_valid, 1'b1);
    check("mark rowv", output_row_valid, 1'b0);
    check("mark addr", output_addr, 16'h0203);
    check("mark hv", output_history_valid_vec, 2'b00);
    check("mark last", output_last, 1'b1);
    check("mark delim", output_delim, 1'b1);
    $display("marker record addr=%h", output_addr);
    next_cycle();
    #1;
    check("mark done", output_valid, 1'b0);

    // backpressure 1,0,0,1 then steady; next beat follows without a bubble
    drive_beat(16'h0500, 4'b1111, 1'b0);
    next_cycle();
    input_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      output_ready = bp_ready[c];
      if (c == 5) drive_beat(16'h0600, 4'b0001, 1'b1);
      #1;
      check_rec($sformatf("bp%0d", c), bp_pos[c], 16'h0500 + 16'(bp_pos[c]), bp_pos[c] == 3, 1'b0);
      check($sformatf("bp%0d in_ready", c), input_ready, c == 5);
      $display("backpressure cycle %0d ready=%0b addr=%h", c, output_ready, output_addr);
      next_cycle();
    end
    input_valid  = 1'b0;
    output_ready = 1'b1;
    #1;
    check_rec("bp next", 0, 16'h0600, 1'b1, 1'b1);
    next_cycle();
    #1;
    check("bp done", output_valid, 1'b0);

    // address wrap
    drive_beat(16'hFFFE, 4'b1111, 1'b0);
    next_cycle();
    input_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check_rec($sformatf("wrap%0d", k), k, wrap_a[k], k == 3, 1'b0);
      $display("wrap record %0d addr=%h", k, output_addr);
      next_cycle();
    end

    // reset in the middle of a beat
    drive_beat(16'hFFFE, 4'b1111, 1'b0);
    next_cycle();
    input_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      check_rec($sformatf("mid%0d", k), k, wrap_a[k], 1'b0, 1'b0);
      next_cycle();
    end
    rst_n = 1'b0;
    #1;
    check("mid rst in_ready", input_ready, 1'b0);
    next_cycle();
    #1;
    check("mid rst valid", output_valid, 1'b0);
    check("mid rst addr", output_addr, 16'h0000);
    check("mid rst lit", output_literal, 8'h00);
    rst_n = 1'b1;
    #1;
    check("mid rel in_ready", input_ready, 1'b1);
    check("mid rel valid", output_valid, 1'b0);
    next_cycle();
    next_cycle();
    #1;
    check("mid no residual", output_valid, 1'b0);
    check("mid idle ready", input_ready, 1'b1);
    $display("reset mid-beat done");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
